// File: rtl/lvt_read_mux_pkg.sv
// Shared helpers for the multi-write-port memory: selector widths, bank indexing, LVT entry type.
package meduram_pkg;

    localparam int unsigned LVT_SELW_MAX = 8;

    typedef logic [LVT_SELW_MAX-1:0] lvt_entry_t;

    // Width of a selector able to name nb items, never narrower than one bit.
    function automatic int unsigned sel_width(input int unsigned nb);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

    // Flat index of bank w within the copy of the bank array serving read agent r.
    function automatic int unsigned bank_index(input int unsigned r,
                                               input int unsigned nb_wr,
                                               input int unsigned w);
        return r * nb_wr + w;
    endfunction

    function automatic lvt_entry_t agent_sel(input int unsigned agent);
        return lvt_entry_t'(agent);
    endfunction

endpackage

// File: rtl/lvt_read_mux_if.sv
// Write-snoop, read-request, bank-data and live-data signals of the LVT read mux.
interface lvt_read_mux_if #(
    parameter int unsigned NB_WRAGENT = 2,
    parameter int unsigned NB_RDAGENT = 1,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [NB_WRAGENT-1:0]                       wren;
    logic [ADDR_WIDTH*NB_WRAGENT-1:0]            wraddr;
    logic [NB_RDAGENT-1:0]                       rden;
    logic [ADDR_WIDTH*NB_RDAGENT-1:0]            rdaddr;
    logic [DATA_WIDTH*NB_WRAGENT*NB_RDAGENT-1:0] bank_rddata;
    logic [DATA_WIDTH*NB_RDAGENT-1:0]            rddata;
    logic [NB_RDAGENT-1:0]                       rdvalid;

    modport master (
        output wren, wraddr, rden, rdaddr, bank_rddata,
        input  rddata, rdvalid
    );

    modport slave (
        input  wren, wraddr, rden, rdaddr, bank_rddata,
        output rddata, rdvalid
    );
endinterface

// File: rtl/lvt_read_mux_read_port.sv
// One read agent: registered LVT selector, valid pipeline, bank word mux and optional output register.
module lvt_read_port
    import meduram_pkg::*;
#(
    parameter int unsigned NB_WRAGENT = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SELW       = 1,
    parameter int unsigned RD_PIPE    = 0
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic                             rden,
    input  logic [SELW-1:0]                  lkup_sel,
    input  logic [DATA_WIDTH*NB_WRAGENT-1:0] bank_words,
    output logic [DATA_WIDTH-1:0]            rddata,
    output logic                             rdvalid
);

    logic [SELW-1:0]       sel_q;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] word_c;

    // Selector is sampled with the bank read so it lines up with the bank's registered data.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sel_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= rden;
            if (rden) begin
                sel_q <= lkup_sel;
            end
        end
    end

    // Unmatched selector values fall back to bank 0, so the output is never X.
    always_comb begin
        word_c = bank_words[DATA_WIDTH-1:0];
        for (int w = 1; w < NB_WRAGENT; w++) begin
            if (sel_q == SELW'(w)) begin
                word_c = bank_words[w*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    generate
        if (RD_PIPE != 0) begin : g_pipe
            logic [DATA_WIDTH-1:0] rddata_q;
            logic                  rdvalid_q;

            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    rddata_q  <= '0;
                    rdvalid_q <= 1'b0;
                end else begin
                    rdvalid_q <= valid_q;
                    if (valid_q) begin
                        rddata_q <= word_c;
                    end
                end
            end

            assign rddata  = rddata_q;
            assign rdvalid = rdvalid_q;
        end else begin : g_direct
            assign rddata  = word_c;
            assign rdvalid = valid_q;
        end
    endgenerate

endmodule

// File: rtl/lvt_read_mux.sv
// Live-value table over per-write-agent banks: records the last writer of each address and
// steers each read agent's bank outputs to the live word.
module lvt_read_mux
    import meduram_pkg::*;
#(
    parameter int unsigned NB_WRAGENT = 2,
    parameter int unsigned NB_RDAGENT = 1,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned RAM_DEPTH  = 2**ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RD_PIPE    = 0
) (
    input logic           aclk,
    input logic           aresetn,
    lvt_read_mux_if.slave bus
);

    localparam int unsigned SELW = sel_width(NB_WRAGENT);
    localparam int unsigned IDXW = sel_width(RAM_DEPTH);

    logic [SELW-1:0] lvt_q [RAM_DEPTH];

    // Ascending scan: on a same-address collision the highest agent index is recorded.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int a = 0; a < RAM_DEPTH; a++) begin
                lvt_q[a] <= '0;
            end
        end else begin
            for (int i = 0; i < NB_WRAGENT; i++) begin
                if (bus.wren[i] &&
                    (32'(bus.wraddr[i*ADDR_WIDTH +: ADDR_WIDTH]) < RAM_DEPTH)) begin
                    lvt_q[IDXW'(bus.wraddr[i*ADDR_WIDTH +: ADDR_WIDTH])] <= SELW'(agent_sel(i));
                end
            end
        end
    end

    generate
        for (genvar r = 0; r < NB_RDAGENT; r++) begin : g_rd
            localparam int unsigned BANK_LSB = bank_index(r, NB_WRAGENT, 0) * DATA_WIDTH;

            logic [ADDR_WIDTH-1:0] addr;
            logic [SELW-1:0]       lkup_sel_c;
            logic [DATA_WIDTH-1:0] port_rddata;
            logic                  port_rdvalid;

            assign addr = bus.rdaddr[r*ADDR_WIDTH +: ADDR_WIDTH];

            // Lookup sees the pre-write table, matching the banks' read-first behaviour.
            always_comb begin
                lkup_sel_c = '0;
                if (32'(addr) < RAM_DEPTH) begin
                    lkup_sel_c = lvt_q[IDXW'(addr)];
                end
            end

            lvt_read_port #(
                .NB_WRAGENT (NB_WRAGENT),
                .DATA_WIDTH (DATA_WIDTH),
                .SELW       (SELW),
                .RD_PIPE    (RD_PIPE)
            ) u_port (
                .aclk       (aclk),
                .aresetn    (aresetn),
                .rden       (bus.rden[r]),
                .lkup_sel   (lkup_sel_c),
                .bank_words (bus.bank_rddata[BANK_LSB +: NB_WRAGENT*DATA_WIDTH]),
                .rddata     (port_rddata),
                .rdvalid    (port_rdvalid)
            );

            assign bus.rddata[r*DATA_WIDTH +: DATA_WIDTH] = port_rddata;
            assign bus.rdvalid[r]                         = port_rdvalid;
        end
    endgenerate

endmodule
